// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the serial pattern detector.
//   state_t      - FSM state encoding (IDLE, HUNT, DONE)
//   MODE_*       - detection mode encodings; 2'b11 is decoded as overlap
//   is_novl()    - true when the latched mode clears fill after a match
//   is_oneshot() - true when a match traps the FSM in DONE
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HUNT = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_OVL     = 2'b00;
  localparam logic [1:0] MODE_NOVL    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  function automatic logic is_novl(input logic [1:0] mode);
    return mode == MODE_NOVL;
  endfunction

  function automatic logic is_oneshot(input logic [1:0] mode);
    return mode == MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// seq_det_window: PAT_LEN-bit shift window, saturating fill counter and
// pattern compare for the serial detector.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   clear           - empties the window and fill (arm/re-arm)
//   shift           - accept x this cycle (already qualified by the FSM)
//   x               - serial data bit, shifted into the LSB
//   clear_on_match  - non-overlap: a match restarts fill from zero
//   pattern         - latched target sequence, MSB is the oldest bit
//   match           - combinational: the bit being accepted completes a match
module seq_det_window #(
  parameter int PAT_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift,
  input  logic               x,
  input  logic               clear_on_match,
  input  logic [PAT_LEN-1:0] pattern,
  output logic               match
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] window_reg, window_next, window_shifted;
  logic [FILL_W-1:0]  fill_reg, fill_next, fill_inc;

  // Match is judged on the post-shift window and fill so that found can be
  // registered on the same edge that accepts the final bit.
  always_comb begin
    window_shifted = {window_reg[PAT_LEN-2:0], x};
    fill_inc       = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);
    match          = shift && (fill_inc == FILL_FULL) && (window_shifted == pattern);

    window_next = window_reg;
    fill_next   = fill_reg;
    if (clear) begin
      window_next = '0;
      fill_next   = '0;
    end else if (shift) begin
      window_next = window_shifted;
      // In non-overlap mode the window contents may stay; zero fill alone
      // guarantees PAT_LEN fresh bits before the next match.
      fill_next   = (match && clear_on_match) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window_reg <= '0;
      fill_reg   <= '0;
    end else begin
      window_reg <= window_next;
      fill_reg   <= fill_next;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: armable serial sequence detector with overlap,
// non-overlap and one-shot modes and a saturating match counter.
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   load       - latch pattern/mode and clear the detector (wins over x_valid)
//   pattern    - target sequence, bit PAT_LEN-1 expected first
//   mode       - 00 overlap, 01 non-overlap, 10 one-shot, 11 as overlap
//   x_valid, x - qualified serial input
//   found      - registered match flag; held high in DONE
//   done       - high while in the one-shot terminal state
//   count      - matches since last load, saturating at all-ones
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [1:0]         mode,
  input  logic               x_valid,
  input  logic               x,
  output logic               found,
  output logic               done,
  output logic [CNT_W-1:0]   count
);

  state_t             state_reg, state_next;
  logic [PAT_LEN-1:0] pattern_reg, pattern_next;
  logic [1:0]         mode_reg, mode_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               found_reg, found_next;
  logic               shift, match;

  // A bit is consumed only while hunting and never on a load cycle.
  assign shift = (state_reg == HUNT) && x_valid && !load;

  seq_det_window #(
    .PAT_LEN (PAT_LEN)
  ) u_window (
    .clk            (clk),
    .reset          (reset),
    .clear          (load),
    .shift          (shift),
    .x              (x),
    .clear_on_match (is_novl(mode_reg)),
    .pattern        (pattern_reg),
    .match          (match)
  );

  always_comb begin
    state_next   = state_reg;
    pattern_next = pattern_reg;
    mode_next    = mode_reg;
    count_next   = count_reg;
    found_next   = 1'b0;

    if (load) begin
      state_next   = HUNT;
      pattern_next = pattern;
      mode_next    = mode;
      count_next   = '0;
    end else begin
      case (state_reg)
        IDLE: ;
        HUNT: begin
          if (match) begin
            found_next = 1'b1;
            if (count_reg != '1)
              count_next = count_reg + CNT_W'(1);
            if (is_oneshot(mode_reg))
              state_next = DONE;
          end
        end
        DONE:    found_next = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pattern_reg <= '0;
      mode_reg    <= MODE_OVL;
      count_reg   <= '0;
      found_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pattern_reg <= pattern_next;
      mode_reg    <= mode_next;
      count_reg   <= count_next;
      found_reg   <= found_next;
    end
  end

  assign found = found_reg;
  assign done  = (state_reg == DONE);
  assign count = count_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  // PAT_LEN=3, CNT_W=8 instance
  logic       ld3, v3, x3;
  logic [2:0] pat3;
  logic [1:0] mode3;
  logic       found3, done3;
  logic [7:0] count3;
  // PAT_LEN=2, CNT_W=2 instance
  logic       ld2, v2, x2;
  logic [1:0] pat2;
  logic [1:0] mode2;
  logic       found2, done2;
  logic [1:0] count2;

  seq_detector_param #(.PAT_LEN(3), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .load(ld3), .pattern(pat3), .mode(mode3),
    .x_valid(v3), .x(x3), .found(found3), .done(done3), .count(count3)
  );

  seq_detector_param #(.PAT_LEN(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .load(ld2), .pattern(pat2), .mode(mode2),
    .x_valid(v2), .x(x2), .found(found2), .done(done2), .count(count2)
  );

  typedef struct {
    logic       ld;
    logic [2:0] pat;
    logic [1:0] mode;
    logic       v;
    logic       x;
    logic       f;
    logic       d;
    logic [7:0] c;
  } vec_t;

  vec_t tbl[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
  endtask

  task automatic add(input logic ld, input logic [2:0] pat, input logic [1:0] mode,
                     input logic v, input logic x, input logic f, input logic d, input logic [7:0] c);
    vec_t r;
    r.ld = ld; r.pat = pat; r.mode = mode; r.v = v; r.x = x; r.f = f; r.d = d; r.c = c;
    tbl.push_back(r);
  endtask

  // Non-load rows carry a different pattern/mode to show they are ignored.
  task automatic arm(input logic [2:0] pat, input logic [1:0] mode);
    add(1'b1, pat, mode, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask
  task automatic bit_in(input logic x, input logic f, input logic d, input logic [7:0] c);
    add(1'b0, 3'b010, 2'b10, 1'b1, x, f, d, c);
  endtask
  task automatic gap(input logic f, input logic d, input logic [7:0] c);
    add(1'b0, 3'b010, 2'b10, 1'b0, 1'b1, f, d, c);
  endtask

  task automatic step3(input logic ld, input logic [2:0] pat, input logic [1:0] mode,
                       input logic v, input logic x);
    ld3 = ld; pat3 = pat; mode3 = mode; v3 = v; x3 = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ld3 = 0; pat3 = 0; mode3 = 0; v3 = 0; x3 = 0;
    ld2 = 0; pat2 = 0; mode2 = 0; v2 = 0; x2 = 0;

    // Build the vector table
    // IDLE: latched pattern is 000, so these zeros would match if not ignored
    bit_in(0, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(0, 0, 0, 0);
    // Overlap, 101 on 1,0,1,0,1
    arm(3'b101, 2'b00);
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 0, 1);
    bit_in(0, 0, 0, 1); bit_in(1, 1, 0, 2); gap(0, 0, 2);
    // Non-overlap
    arm(3'b101, 2'b01);
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 0, 1);
    bit_in(0, 0, 0, 1); bit_in(1, 0, 0, 1);
    // Mode 11 behaves as overlap
    arm(3'b101, 2'b11);
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 0, 1);
    bit_in(0, 0, 0, 1); bit_in(1, 1, 0, 2);
    // One-shot, then re-arm in overlap
    arm(3'b101, 2'b10);
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 1, 1);
    bit_in(1, 1, 1, 1); bit_in(0, 1, 1, 1); gap(1, 1, 1);
    arm(3'b101, 2'b00);
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 0, 1);
    // x_valid gaps between bits
    arm(3'b101, 2'b00);
    bit_in(1, 0, 0, 0); gap(0, 0, 0); bit_in(0, 0, 0, 0);
    gap(0, 0, 0); gap(0, 0, 0); bit_in(1, 1, 0, 1);
    // Load on the final matching bit discards it and clears the window
    arm(3'b101, 2'b00);
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0);
    add(1'b1, 3'b101, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 0, 1);

    // Asynchronous reset
    #3 reset = 1'b0;
    #1;
    check("rst_found3", 0, found3, 0);
    check("rst_done3",  0, done3,  0);
    check("rst_count3", 0, count3, 0);
    check("rst_count2", 0, count2, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Table-driven section on the PAT_LEN=3 instance
    for (int i = 0; i < tbl.size(); i++) begin
      step3(tbl[i].ld, tbl[i].pat, tbl[i].mode, tbl[i].v, tbl[i].x);
      check("tbl_found", i, found3, tbl[i].f);
      check("tbl_done",  i, done3,  tbl[i].d);
      check("tbl_count", i, count3, tbl[i].c);
      $display("vec %0d: ld=%0b v=%0b x=%0b -> found=%0b done=%0b count=%0d",
               i, tbl[i].ld, tbl[i].v, tbl[i].x, found3, done3, count3);
    end
    step3(0, 0, 0, 0, 0);

    // Saturating counter on PAT_LEN=2, CNT_W=2, pattern 11, six 1s
    ld2 = 1; pat2 = 2'b11; mode2 = 2'b00; v2 = 0; x2 = 0;
    @(posedge clk); #1;
    check("sat_found", 0, found2, 0);
    check("sat_count", 0, count2, 0);
    ld2 = 0; pat2 = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      v2 = 1; x2 = 1;
      @(posedge clk); #1;
      check("sat_found", k, found2, (k >= 2) ? 1 : 0);
      check("sat_count", k, count2, (k - 1 > 3) ? 3 : k - 1);
      $display("sat bit %0d: found=%0b count=%0d", k, found2, count2);
    end
    v2 = 0; x2 = 0;

    // Reset out of DONE mid-cycle, then bits without load are ignored
    step3(1, 3'b101, 2'b10, 0, 0);
    step3(0, 3'b101, 2'b10, 1, 1);
    step3(0, 3'b101, 2'b10, 1, 0);
    step3(0, 3'b101, 2'b10, 1, 1);
    check("pre_rst_done",  0, done3,  1);
    check("pre_rst_count", 0, count3, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_found", 0, found3, 0);
    check("mid_rst_done",  0, done3,  0);
    check("mid_rst_count", 0, count3, 0);
    check("mid_rst_count2", 0, count2, 0);
    #2 reset = 1'b1;
    step3(0, 3'b101, 2'b00, 1, 1);
    step3(0, 3'b101, 2'b00, 1, 0);
    step3(0, 3'b101, 2'b00, 1, 1);
    check("post_rst_idle_found", 0, found3, 0);
    check("post_rst_idle_count", 0, count3, 0);
    // Partial progress 1,0 then reset, then load, then 1 -> no match
    step3(1, 3'b101, 2'b00, 0, 0);
    step3(0, 3'b101, 2'b00, 1, 1);
    step3(0, 3'b101, 2'b00, 1, 0);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    step3(1, 3'b101, 2'b00, 0, 0);
    step3(0, 3'b101, 2'b00, 1, 1);
    check("rearm_found", 0, found3, 0);
    check("rearm_count", 0, count3, 0);
    $display("reset sequence: found=%0b done=%0b count=%0d", found3, done3, count3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-003 Port clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-low.
REQ-005 Port load  input  1  arm strobe; latches pattern and mode, then clears the detector.
REQ-006 Port pattern  input  PAT_LEN  target sequence; bit PAT_LEN-1 is the first bit expected.
REQ-007 Port mode  input  2  detection mode: 00 overlap, 01 non-overlap, 10 one-shot, 11 treated as 00.
REQ-008 Port x_valid  input  1  qualifies x; x is sampled only when x_valid=1.
REQ-009 Port x  input  1  serial data bit.
REQ-010 Port found  output  1  registered match indicator (Moore).
REQ-011 Port done  output  1  high while in DONE state (one-shot terminal).
REQ-012 Port count  output  CNT_W  number of matches since last load, saturating.

Function
REQ-013 States SHALL be IDLE (unarmed), HUNT (searching) and DONE (one-shot terminal trap).
REQ-014 In IDLE, x and x_valid SHALL be ignored; only load leaves IDLE (to HUNT).
REQ-015 On load=1 in any state: latch pattern and mode, clear window, fill=0, count=0, found=0; next state HUNT.
REQ-016 load SHALL take priority over a simultaneous x_valid; that bit is discarded.
REQ-017 In HUNT with x_valid=1: shift x into LSB of a PAT_LEN-bit window; fill increments, saturating at PAT_LEN.
REQ-018 A match SHALL occur when the updated fill equals PAT_LEN and the updated window equals the latched pattern.
REQ-019 found SHALL be 1 in the cycle after the edge accepting the final matching bit (zero extra latency), and 0 otherwise in modes 00/01.
REQ-020 Each match SHALL increment count by 1, holding at all-ones when saturated (no wrap).
REQ-021 Mode 00: after a match the window and fill are retained, so overlapping matches are detected.
REQ-022 Mode 01: after a match fill SHALL be cleared to 0, so no bit contributes to two matches.
REQ-023 Mode 10: a match SHALL move to DONE; found and done then stay 1 and x is ignored until load or reset.
REQ-024 x_valid=0 cycles SHALL leave window, fill, count and state unchanged, and SHALL drive found=0 except in DONE.
REQ-025 Mode and pattern changes without load SHALL have no effect.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, window=0, fill=0, count=0, found=0, done=0, latched pattern=0, latched mode=00.
REQ-027 Reset asserted mid-sequence SHALL discard partial progress; a fresh load is needed before detection resumes.

Structure
REQ-028 Package seq_det_pkg SHALL hold the state encoding (IDLE, HUNT, DONE) and the mode constants (MODE_OVL, MODE_NOVL, MODE_ONESHOT).
REQ-029 Sub-module seq_det_window SHALL implement the shift window, fill counter and compare, and output a match flag; the top holds the FSM, counter and outputs.

Verification
REQ-030 PAT_LEN=3, pattern 101, mode 00, bits 1,0,1,0,1 -> found pulses after bits 3 and 5; count=2.
REQ-031 Same stimulus in mode 01 -> single found pulse after bit 3; count=1.
REQ-032 Mode 10, pattern 101, bits 1,0,1,1,0 -> found=done=1 from bit 3 onward, held; count=1; then load -> found=done=0, count=0, state HUNT.
REQ-033 CNT_W=2, PAT_LEN=2, pattern 11, mode 00, six 1s -> found pulses after bits 2..6; count 1,2,3,3,3.
REQ-034 Pattern 101, bits 1,0 then reset pulse, then load, then bit 1 -> no match; count=0. Bits 1,gap,0,gap,gap,1 with x_valid gaps -> one match.
REQ-035 load asserted with x_valid=1, x=1 on the final bit of 101 -> no match; count=0, window cleared.
